// File: rtl/mem_to_stream.sv
// rtl/mem_to_stream.sv - memory-side responder bridging a no-backpressure response master to a stream backend
// Optional macro MEM_TO_STREAM_RESP_FALL_THROUGH_EN lets read data bypass the buffer when it is empty.
module mem_to_stream #(
    parameter type         mem_req_t  = logic,
    parameter type         mem_resp_t = logic,
    parameter int unsigned BufDepth   = 32'd2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  mem_req_t                      req_i,
    input  logic                          req_we_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    output mem_resp_t                     resp_o,
    output logic                          resp_valid_o,
    output mem_req_t                      stream_req_o,
    output logic                          stream_req_we_o,
    output logic                          stream_req_valid_o,
    input  logic                          stream_req_ready_i,
    input  mem_resp_t                     stream_resp_i,
    input  logic                          stream_resp_valid_i,
    output logic                          stream_resp_ready_o,
    output logic [$clog2(BufDepth+1)-1:0] outstanding_o
);

    localparam int unsigned CW = $clog2(BufDepth + 1);
    localparam int unsigned PW = (BufDepth > 1) ? $clog2(BufDepth) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BufDepth);
    localparam logic [PW-1:0] LAST_C  = PW'(BufDepth - 1);

    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] rd_wait_q;
    logic [CW-1:0] dcnt_q;

    logic          order_mem [BufDepth];
    logic [PW-1:0] owr_ptr_q;
    logic [PW-1:0] ord_ptr_q;

    mem_resp_t     buf_mem [BufDepth];
    logic [PW-1:0] bwr_ptr_q;
    logic [PW-1:0] brd_ptr_q;

    logic order_empty;
    logic buf_empty;
    logic head_we;
    logic resp_hs;
    logic ft;
    logic retire;
    logic slot_free;
    logic accept;
    logic buf_push;
    logic buf_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    assign order_empty = (outstanding_q == '0);
    assign buf_empty   = (dcnt_q == '0);
    assign head_we     = order_mem[ord_ptr_q];

    assign stream_resp_ready_o = ~rst_i & (rd_wait_q != '0);
    assign resp_hs             = stream_resp_valid_i & stream_resp_ready_o;

`ifdef MEM_TO_STREAM_RESP_FALL_THROUGH_EN
    assign ft = ~order_empty & ~head_we & buf_empty & resp_hs;
`else
    assign ft = 1'b0;
`endif

    // A write head retires on its own; a read head needs buffered (or bypassed) data.
    assign retire  = ~rst_i & ~order_empty & (head_we | ~buf_empty | ft);
    assign buf_pop = retire & ~head_we & ~buf_empty;
    assign buf_push = resp_hs & ~ft;

    assign slot_free          = (outstanding_q < DEPTH_C) | retire;
    assign stream_req_valid_o = ~rst_i & req_valid_i & slot_free;
    assign req_ready_o        = ~rst_i & stream_req_ready_i & slot_free;
    assign accept             = req_valid_i & req_ready_o;

    assign stream_req_o    = req_i;
    assign stream_req_we_o = req_we_i;

    assign resp_valid_o  = retire;
    assign outstanding_o = outstanding_q;

    always_comb begin
        resp_o = '0;
        if (retire && !head_we) begin
            resp_o = buf_empty ? stream_resp_i : buf_mem[brd_ptr_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
            rd_wait_q     <= '0;
            dcnt_q        <= '0;
            owr_ptr_q     <= '0;
            ord_ptr_q     <= '0;
            bwr_ptr_q     <= '0;
            brd_ptr_q     <= '0;
        end else begin
            if (accept && !retire) begin
                outstanding_q <= outstanding_q + CW'(1);
            end else if (!accept && retire) begin
                outstanding_q <= outstanding_q - CW'(1);
            end

            if ((accept && !req_we_i) && !resp_hs) begin
                rd_wait_q <= rd_wait_q + CW'(1);
            end else if (!(accept && !req_we_i) && resp_hs) begin
                rd_wait_q <= rd_wait_q - CW'(1);
            end

            if (buf_push && !buf_pop) begin
                dcnt_q <= dcnt_q + CW'(1);
            end else if (!buf_push && buf_pop) begin
                dcnt_q <= dcnt_q - CW'(1);
            end

            if (accept) begin
                owr_ptr_q <= ptr_inc(owr_ptr_q);
            end
            if (retire) begin
                ord_ptr_q <= ptr_inc(ord_ptr_q);
            end
            if (buf_push) begin
                bwr_ptr_q <= ptr_inc(bwr_ptr_q);
            end
            if (buf_pop) begin
                brd_ptr_q <= ptr_inc(brd_ptr_q);
            end
        end
    end

    // Storage is not reset; pointers and counters alone define validity.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            order_mem[owr_ptr_q] <= req_we_i;
        end
        if (buf_push) begin
            buf_mem[bwr_ptr_q] <= stream_resp_i;
        end
    end

endmodule

// File: tb/tb_mem_to_stream.sv
// tb/tb_mem_to_stream.sv - directed self-checking bench for mem_to_stream
module tb_mem_to_stream;

`ifdef MEM_TO_STREAM_RESP_FALL_THROUGH_EN
    localparam bit FT = 1'b1;
`else
    localparam bit FT = 1'b0;
`endif

    typedef logic [15:0] req_t;
    typedef logic [7:0]  resp_t;

    logic       clk = 1'b0;
    logic       rst;
    req_t       req;
    logic       req_we;
    logic       req_valid;
    logic       req_ready;
    resp_t      resp;
    logic       resp_valid;
    req_t       s_req;
    logic       s_req_we;
    logic       s_req_valid;
    logic       s_req_ready;
    resp_t      s_resp;
    logic       s_resp_valid;
    logic       s_resp_ready;
    logic [1:0] outstanding;

    int tests = 0;
    int fails = 0;

    mem_to_stream #(
        .mem_req_t (req_t),
        .mem_resp_t(resp_t),
        .BufDepth  (2)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .req_i              (req),
        .req_we_i           (req_we),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .resp_o             (resp),
        .resp_valid_o       (resp_valid),
        .stream_req_o       (s_req),
        .stream_req_we_o    (s_req_we),
        .stream_req_valid_o (s_req_valid),
        .stream_req_ready_i (s_req_ready),
        .stream_resp_i      (s_resp),
        .stream_resp_valid_i(s_resp_valid),
        .stream_resp_ready_o(s_resp_ready),
        .outstanding_o      (outstanding)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input req_t r, input logic sv, input resp_t sd);
        req_valid    = v;
        req_we       = we;
        req         = r;
        s_resp_valid = sv;
        s_resp       = sd;
    endtask

    initial begin
        rst = 1'b1;
        s_req_ready = 1'b1;
        drive(1'b1, 1'b0, 16'h0, 1'b1, 8'h0);
        cyc();
        #4;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_s_req_valid", s_req_valid, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_s_resp_ready", s_resp_ready, 0);
        chk("rst_outstanding", outstanding, 0);
        cyc();
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 1'b0, 8'h0);
        #4;
        chk("idle_req_ready", req_ready, 1);
        chk("idle_outstanding", outstanding, 0);
        cyc();

        // single read, data at c3
        drive(1'b1, 1'b0, 16'h1234, 1'b0, 8'h0);
        #4;
        chk("rd_req_ready", req_ready, 1);
        chk("rd_s_req_valid", s_req_valid, 1);
        chk("rd_s_req", s_req, 16'h1234);
        chk("rd_s_req_we", s_req_we, 0);
        cyc();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 8'h0);
        #4;
        chk("rd_c1_outstanding", outstanding, 1);
        chk("rd_c1_s_resp_ready", s_resp_ready, 1);
        chk("rd_c1_resp_valid", resp_valid, 0);
        cyc();
        #4;
        chk("rd_c2_resp_valid", resp_valid, 0);
        cyc();
        drive(1'b0, 1'b0, 16'h0, 1'b1, 8'hA5);
        #4;
        chk("rd_c3_resp_valid", resp_valid, FT);
        if (FT) chk("rd_c3_resp", resp, 8'hA5);
        cyc();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 8'h0);
        #4;
        chk("rd_c4_resp_valid", resp_valid, !FT);
        if (!FT) chk("rd_c4_resp", resp, 8'hA5);
        chk("rd_c4_outstanding", outstanding, FT ? 0 : 1);
        cyc();
        #4;
        chk("rd_c5_outstanding", outstanding, 0);
        chk("rd_c5_resp_valid", resp_valid, 0);
        cyc();

        // posted write
        drive(1'b1, 1'b1, 16'h5555, 1'b0, 8'h0);
        #4;
        chk("wr_s_req_we", s_req_we, 1);
        chk("wr_req_ready", req_ready, 1);
        chk("wr_resp_valid_c0", resp_valid, 0);
        cyc();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 8'h0);
        #4;
        chk("wr_ack_valid", resp_valid, 1);
        chk("wr_ack_data", resp, 0);
        chk("wr_outstanding", outstanding, 1);
        chk("wr_s_resp_ready", s_resp_ready, 0);
        cyc();
        #4;
        chk("wr_c2_outstanding", outstanding, 0);
        chk("wr_c2_resp_valid", resp_valid, 0);
        cyc();

        // ordering: R0 c0, W1 c1, R0 data at c5
        drive(1'b1, 1'b0, 16'h0100, 1'b0, 8'h0);
        cyc();
        drive(1'b1, 1'b1, 16'h0101, 1'b0, 8'h0);
        #4;
        chk("ord_c1_req_ready", req_ready, 1);
        cyc();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 8'h0);
        for (int i = 2; i < 5; i++) begin
            #4;
            chk("ord_wait_resp_valid", resp_valid, 0);
            chk("ord_wait_outstanding", outstanding, 2);
            cyc();
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1, 8'h3C);
        #4;
        chk("ord_c5_resp_valid", resp_valid, FT);
        if (FT) chk("ord_c5_resp", resp, 8'h3C);
        cyc();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 8'h0);
        #4;
        chk("ord_c6_resp_valid", resp_valid, 1);
        chk("ord_c6_resp", resp, FT ? 8'h00 : 8'h3C);
        cyc();
        #4;
        chk("ord_c7_resp_valid", resp_valid, !FT);
        if (!FT) chk("ord_c7_wack", resp, 0);
        cyc();
        #4;
        chk("ord_c8_outstanding", outstanding, 0);
        cyc();

        // credit limit: two reads then a write
        drive(1'b1, 1'b0, 16'h0200, 1'b0, 8'h0);
        cyc();
        drive(1'b1, 1'b0, 16'h0201, 1'b0, 8'h0);
        #4;
        chk("cr_c1_req_ready", req_ready, 1);
        cyc();
        drive(1'b1, 1'b1, 16'h0202, 1'b1, 8'h11);
        #4;
        chk("cr_c2_outstanding", outstanding, 2);
        chk("cr_c2_req_ready", req_ready, FT);
        chk("cr_c2_s_req_valid", s_req_valid, FT);
        chk("cr_c2_resp_valid", resp_valid, FT);
        cyc();
        drive(!FT, 1'b1, 16'h0202, 1'b0, 8'h0);
        #4;
        chk("cr_c3_outstanding", outstanding, 2);
        if (!FT) begin
            chk("cr_c3_req_ready", req_ready, 1);
            chk("cr_c3_resp_valid", resp_valid, 1);
            chk("cr_c3_resp", resp, 8'h11);
        end
        cyc();
        drive(1'b0, 1'b0, 16'h0, 1'b1, 8'h22);
        #4;
        chk("cr_c4_outstanding", outstanding, 2);
        chk("cr_c4_s_resp_ready", s_resp_ready, 1);
        cyc();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 8'h0);
        for (int i = 0; i < 4; i++) cyc();
        #4;
        chk("cr_drain_outstanding", outstanding, 0);
        chk("cr_drain_s_resp_ready", s_resp_ready, 0);
        cyc();

        // backpressure and stray data
        s_req_ready = 1'b0;
        drive(1'b1, 1'b0, 16'h0300, 1'b0, 8'h0);
        #4;
        chk("bp_req_ready", req_ready, 0);
        chk("bp_s_req_valid", s_req_valid, 1);
        cyc();
        #4;
        chk("bp_outstanding", outstanding, 0);
        cyc();
        s_req_ready = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 1'b1, 8'hEE);
        #4;
        chk("stray_s_resp_ready", s_resp_ready, 0);
        chk("stray_resp_valid", resp_valid, 0);
        cyc();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 8'h0);
        #4;
        chk("stray_after_resp_valid", resp_valid, 0);
        chk("stray_after_outstanding", outstanding, 0);
        cyc();

        // reset mid-operation
        drive(1'b1, 1'b0, 16'h0400, 1'b0, 8'h0);
        cyc();
        drive(1'b1, 1'b0, 16'h0401, 1'b0, 8'h0);
        cyc();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 8'h0);
        rst = 1'b1;
        #4;
        chk("mr_rst_req_ready", req_ready, 0);
        chk("mr_rst_resp_valid", resp_valid, 0);
        chk("mr_rst_s_resp_ready", s_resp_ready, 0);
        cyc();
        rst = 1'b0;
        #4;
        chk("mr_outstanding", outstanding, 0);
        chk("mr_resp_valid", resp_valid, 0);
        chk("mr_s_resp_ready", s_resp_ready, 0);
        cyc();
        drive(1'b0, 1'b0, 16'h0, 1'b1, 8'h77);
        for (int i = 0; i < 3; i++) begin
            #4;
            chk("mr_late_s_resp_ready", s_resp_ready, 0);
            chk("mr_late_resp_valid", resp_valid, 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
